// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch-metric pipeline: per-codeword distances from soft
// received bits, then normalisation against the minimum plus best index.
module bmc_soft_pipe #(
  parameter int unsigned SYM_W  = 3,
  parameter int unsigned N_CODE = 2
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [N_CODE*SYM_W-1:0]                             rx_sym,
  input  logic [N_CODE-1:0]                                   erase,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [(2**N_CODE)*(SYM_W+$clog2(N_CODE))-1:0]       bm,
  output logic [N_CODE-1:0]                                   out_best,
  output logic [15:0]                                         sym_cnt
);

  localparam int unsigned CW   = 2 ** N_CODE;
  localparam int unsigned MAXS = (2 ** SYM_W) - 1;
  localparam int unsigned BM_W = SYM_W + $clog2(N_CODE);
  localparam int unsigned CNT_W = 16;

  typedef logic [CW-1:0][BM_W-1:0] metrics_t;

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  metrics_t          raw_q, raw_d, raw_c;
  metrics_t          bm_q, bm_d;
  logic [N_CODE-1:0] best_q, best_d, best_c;
  logic [BM_W-1:0]   min_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s1_adv, s2_adv, accept, out_hs;

  // Pipeline advance and handshake qualifiers
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    accept = in_valid && s1_adv;
    out_hs = s2_valid_q && out_ready;
  end

  // Raw metric per codeword: erased bits contribute nothing
  always_comb begin
    raw_c = '0;
    for (int c = 0; c < CW; c++) begin
      for (int i = 0; i < N_CODE; i++) begin
        if (!erase[i]) begin
          if (((c >> i) & 1) != 0) begin
            raw_c[c] = raw_c[c] + BM_W'(SYM_W'(MAXS) - rx_sym[i*SYM_W +: SYM_W]);
          end else begin
            raw_c[c] = raw_c[c] + BM_W'(rx_sym[i*SYM_W +: SYM_W]);
          end
        end
      end
    end
  end

  // Minimum search over stage-1 metrics; strict compare keeps the lowest index on ties
  always_comb begin
    min_c  = raw_q[0];
    best_c = '0;
    for (int c = 1; c < CW; c++) begin
      if (raw_q[c] < min_c) begin
        min_c  = raw_q[c];
        best_c = N_CODE'(c);
      end
    end
  end

  // Next-state for both stages and the output handshake counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    raw_d      = raw_q;
    s2_valid_d = s2_valid_q;
    bm_d       = bm_q;
    best_d     = best_q;
    cnt_d      = cnt_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        raw_d = raw_c;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int c = 0; c < CW; c++) begin
          bm_d[c] = raw_q[c] - min_c;
        end
        best_d = best_c;
      end
    end
    if (out_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      raw_q      <= '0;
      bm_q       <= '0;
      best_q     <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      raw_q      <= raw_d;
      bm_q       <= bm_d;
      best_q     <= best_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign bm        = bm_q;
  assign out_best  = best_q;
  assign sym_cnt   = cnt_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Scoreboard bench for bmc_soft_pipe (SYM_W=3 and SYM_W=1 instances).
module tb_bmc_soft_pipe;

  localparam int unsigned SW  = 3;
  localparam int unsigned NC  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned BW  = 4;
  localparam int unsigned SW1 = 1;
  localparam int unsigned BW1 = 2;

  typedef struct {
    int m[4];
    int best;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic              in_valid, in_ready, out_valid, out_ready;
  logic [NC*SW-1:0]  rx_sym;
  logic [NC-1:0]     erase;
  logic [CW*BW-1:0]  bm;
  logic [NC-1:0]     out_best;
  logic [15:0]       sym_cnt;

  logic              in_valid1, in_ready1, out_valid1, out_ready1;
  logic [NC*SW1-1:0] rx_sym1;
  logic [NC-1:0]     erase1;
  logic [CW*BW1-1:0] bm1;
  logic [NC-1:0]     out_best1;
  logic [15:0]       sym_cnt1;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  exp_t q1[$];

  bmc_soft_pipe #(.SYM_W(SW), .N_CODE(NC)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rx_sym(rx_sym), .erase(erase), .out_valid(out_valid), .out_ready(out_ready),
    .bm(bm), .out_best(out_best), .sym_cnt(sym_cnt)
  );

  bmc_soft_pipe #(.SYM_W(SW1), .N_CODE(NC)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .rx_sym(rx_sym1), .erase(erase1), .out_valid(out_valid1), .out_ready(out_ready1),
    .bm(bm1), .out_best(out_best1), .sym_cnt(sym_cnt1)
  );

  always #5 clk = ~clk;

  // Reference metrics: sum distances, then scan downward so ties land on the lowest index
  function automatic exp_t model(input int sw, input int s0, input int s1, input int er);
    exp_t e;
    int raw[4];
    int s[2];
    int maxs, mn;
    maxs = (1 << sw) - 1;
    s[0] = s0;
    s[1] = s1;
    for (int c = 0; c < 4; c++) begin
      raw[c] = 0;
      for (int i = 0; i < 2; i++) begin
        if (((er >> i) & 1) == 0) raw[c] += (((c >> i) & 1) == 1) ? (maxs - s[i]) : s[i];
      end
    end
    mn = raw[3];
    e.best = 3;
    for (int c = 2; c >= 0; c--) begin
      if (raw[c] <= mn) begin
        mn = raw[c];
        e.best = c;
      end
    end
    for (int c = 0; c < 4; c++) e.m[c] = raw[c] - mn;
    return e;
  endfunction

  function automatic logic [15:0] pack(input exp_t e, input int bw);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r = r | (16'(e.m[c]) << (c * bw));
    return r;
  endfunction

  task automatic set_in(input logic v, input int s0, input int s1, input int er, input logic ordy);
    in_valid  = v;
    rx_sym    = {SW'(s1), SW'(s0)};
    erase     = NC'(er);
    out_ready = ordy;
  endtask

  task automatic apply_reset();
    set_in(1'b0, 0, 0, 0, 1'b1);
    in_valid1 = 1'b0; rx_sym1 = '0; erase1 = '0; out_ready1 = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    set_in(1'b0, 0, 0, 0, 1'b1);
    in_valid1 = 1'b0; rx_sym1 = '0; erase1 = '0; out_ready1 = 1'b1;
    rst_n = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (bm !== 16'h0) begin n_err++; $display("FAIL reset_bm: got %h required 0000", bm); end
    n_cmp++; if (sym_cnt !== 16'h0) begin n_err++; $display("FAIL reset_sym_cnt: got %h required 0000", sym_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    int lat;
    apply_reset();
    e.m = '{7, 14, 0, 7};
    e.best = 2;
    @(negedge clk);
    set_in(1'b1, 0, 7, 0, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b required 1", in_ready); end
    if (in_valid && in_ready) q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      set_in(1'b0, 0, 0, 0, 1'b1);
      #1;
      lat++;
    end while (!out_valid && lat < 8);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL basic_latency: got %0d cycles required 2", lat); end
    if (out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin n_err++; $display("FAIL basic_spurious: output with empty scoreboard"); end
      else begin
        e = q.pop_front();
        if (bm !== pack(e, BW) || out_best !== NC'(e.best)) begin
          n_err++; $display("FAIL basic_data: bm=%h best=%0d required bm=%h best=%0d", bm, out_best, pack(e, BW), e.best);
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (sym_cnt !== 16'd1) begin n_err++; $display("FAIL basic_sym_cnt: got %0d required 1", sym_cnt); end
  endtask

  task automatic test_erase_tie();
    exp_t e;
    int cyc;
    apply_reset();
    e.m = '{0, 3, 0, 3};
    e.best = 0;
    @(negedge clk);
    set_in(1'b1, 2, 6, 2, 1'b1);
    #1;
    if (in_valid && in_ready) q.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      set_in(1'b0, 0, 0, 0, 1'b1);
      #1;
      cyc++;
    end while (!out_valid && cyc < 8);
    n_cmp++;
    if (!out_valid || q.size() == 0) begin n_err++; $display("FAIL tie_timeout: out_valid=%b queued=%0d required an output", out_valid, q.size()); end
    else begin
      e = q.pop_front();
      if (bm !== pack(e, BW) || out_best !== NC'(e.best)) begin
        n_err++; $display("FAIL tie_data: bm=%h best=%0d required bm=%h best=%0d", bm, out_best, pack(e, BW), e.best);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int s0[5], s1[5], er[5];
    int sent, got, t;
    logic [15:0] held_bm;
    logic [NC-1:0] held_best;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      s0[k] = $urandom_range(7, 0); s1[k] = $urandom_range(7, 0); er[k] = $urandom_range(3, 0);
    end
    sent = 0; got = 0; t = 0;
    held_bm = '0; held_best = '0;
    while (got < 5 && t < 40) begin
      @(negedge clk);
      if (sent < 5) set_in(1'b1, s0[sent], s1[sent], er[sent], !(t >= 2 && t <= 4));
      else set_in(1'b0, 0, 0, 0, 1'b1);
      #1;
      if (t <= 4) begin
        n_cmp++;
        if (in_ready !== ((t < 2) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL bp_in_ready t=%0d: got %b required %b", t, in_ready, (t < 2)); end
      end
      if (t == 2) begin held_bm = bm; held_best = out_best; end
      if (t == 3 || t == 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || bm !== held_bm || out_best !== held_best) begin
          n_err++; $display("FAIL bp_hold t=%0d: valid=%b bm=%h best=%0d required valid=1 bm=%h best=%0d", t, out_valid, bm, out_best, held_bm, held_best);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL bp_spurious: output with empty scoreboard"); end
        else begin
          e = q.pop_front();
          if (bm !== pack(e, BW) || out_best !== NC'(e.best)) begin
            n_err++; $display("FAIL bp_data #%0d: bm=%h best=%0d required bm=%h best=%0d", got, bm, out_best, pack(e, BW), e.best);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(model(SW, s0[sent], s1[sent], er[sent])); sent++; end
      t++;
    end
    @(negedge clk);
    set_in(1'b0, 0, 0, 0, 1'b1);
    #1;
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL bp_count: got %0d outputs required 5", got); end
    n_cmp++; if (sym_cnt !== 16'd5) begin n_err++; $display("FAIL bp_sym_cnt: got %0d required 5", sym_cnt); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int s0, s1, er, sent, got, cyc, ir_bad;
    apply_reset();
    s0 = $urandom_range(7, 0); s1 = $urandom_range(7, 0); er = $urandom_range(3, 0);
    sent = 0; got = 0; cyc = 0; ir_bad = 0;
    while (got < 20 && cyc < 60) begin
      @(negedge clk);
      set_in(sent < 20, s0, s1, er, 1'b1);
      #1;
      if (in_ready !== 1'b1) ir_bad++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL b2b_spurious: output with empty scoreboard"); end
        else begin
          e = q.pop_front();
          if (bm !== pack(e, BW) || out_best !== NC'(e.best)) begin
            n_err++; $display("FAIL b2b_data #%0d: bm=%h best=%0d required bm=%h best=%0d", got, bm, out_best, pack(e, BW), e.best);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(SW, s0, s1, er)); sent++;
        s0 = $urandom_range(7, 0); s1 = $urandom_range(7, 0); er = $urandom_range(3, 0);
      end
      cyc++;
    end
    n_cmp++; if (ir_bad !== 0) begin n_err++; $display("FAIL b2b_in_ready: low in %0d cycles required 0", ir_bad); end
    n_cmp++; if (cyc !== 22) begin n_err++; $display("FAIL b2b_throughput: %0d cycles for 20 symbols required 22", cyc); end
  endtask

  task automatic test_random();
    exp_t e;
    int s0, s1, er, sent, got, cyc;
    apply_reset();
    s0 = $urandom_range(7, 0); s1 = $urandom_range(7, 0); er = $urandom_range(3, 0);
    sent = 0; got = 0; cyc = 0;
    while (got < 30 && cyc < 400) begin
      @(negedge clk);
      set_in((sent < 30) && ($urandom_range(3, 0) != 0), s0, s1, er, $urandom_range(3, 0) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rand_spurious: output with empty scoreboard"); end
        else begin
          e = q.pop_front();
          if (bm !== pack(e, BW) || out_best !== NC'(e.best)) begin
            n_err++; $display("FAIL rand_data #%0d: bm=%h best=%0d required bm=%h best=%0d", got, bm, out_best, pack(e, BW), e.best);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(SW, s0, s1, er)); sent++;
        s0 = $urandom_range(7, 0); s1 = $urandom_range(7, 0); er = $urandom_range(3, 0);
      end
      cyc++;
    end
    @(negedge clk);
    set_in(1'b0, 0, 0, 0, 1'b1);
    #1;
    n_cmp++; if (got !== 30) begin n_err++; $display("FAIL rand_count: got %0d outputs required 30", got); end
    n_cmp++; if (sym_cnt !== 16'd30) begin n_err++; $display("FAIL rand_sym_cnt: got %0d required 30", sym_cnt); end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int stale, cyc;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(1'b1, k + 1, 6 - k, 0, 1'b0);
    end
    @(negedge clk);
    set_in(1'b0, 0, 0, 0, 1'b0);
    #1;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full: valid=%b in_ready=%b required 1/0", out_valid, in_ready); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1 || bm !== 16'h0) begin n_err++; $display("FAIL mid_async_state: in_ready=%b bm=%h required 1/0000", in_ready, bm); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 0, 0, 0, 1'b1);
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL mid_stale: out_valid seen %0d cycles required 0", stale); end
    @(negedge clk);
    set_in(1'b1, 5, 1, 0, 1'b1);
    #1;
    if (in_valid && in_ready) q.push_back(model(SW, 5, 1, 0));
    cyc = 0;
    do begin
      @(negedge clk);
      set_in(1'b0, 0, 0, 0, 1'b1);
      #1;
      cyc++;
    end while (!out_valid && cyc < 8);
    n_cmp++;
    if (!out_valid || q.size() == 0) begin n_err++; $display("FAIL mid_timeout: out_valid=%b queued=%0d required an output", out_valid, q.size()); end
    else begin
      e = q.pop_front();
      if (bm !== pack(e, BW) || out_best !== NC'(e.best)) begin
        n_err++; $display("FAIL mid_data: bm=%h best=%0d required bm=%h best=%0d", bm, out_best, pack(e, BW), e.best);
      end
    end
  endtask

  task automatic test_sym_w1();
    exp_t e;
    int got, cyc;
    apply_reset();
    e.m = '{2, 1, 1, 0}; e.best = 3;
    @(negedge clk);
    in_valid1 = 1'b1; rx_sym1 = 2'b11; erase1 = 2'b00; out_ready1 = 1'b1;
    #1;
    if (in_valid1 && in_ready1) q1.push_back(e);
    e.m = '{0, 0, 0, 0}; e.best = 0;
    @(negedge clk);
    in_valid1 = 1'b1; rx_sym1 = 2'b11; erase1 = 2'b11;
    #1;
    if (in_valid1 && in_ready1) q1.push_back(e);
    got = 0; cyc = 0;
    while (got < 2 && cyc < 10) begin
      if (out_valid1 && out_ready1) begin
        n_cmp++;
        if (q1.size() == 0) begin n_err++; $display("FAIL w1_spurious: output with empty scoreboard"); end
        else begin
          e = q1.pop_front();
          if (bm1 !== 8'(pack(e, BW1)) || out_best1 !== NC'(e.best)) begin
            n_err++; $display("FAIL w1_data #%0d: bm=%h best=%0d required bm=%h best=%0d", got, bm1, out_best1, 8'(pack(e, BW1)), e.best);
          end
        end
        got++;
      end
      @(negedge clk);
      in_valid1 = 1'b0;
      #1;
      cyc++;
    end
    n_cmp++; if (got !== 2) begin n_err++; $display("FAIL w1_count: got %0d outputs required 2", got); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_erase_tie();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    test_sym_w1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bmc_soft_pipe.md
BMC_SOFT_PIPE -- requirements
Module: bmc_soft_pipe

Interface
REQ-001 The block SHALL have parameter SYM_W, default 3, meaning soft-decision bits per received code bit; legal range 1..6, where 1 gives hard-decision Hamming metrics.
REQ-002 The block SHALL have parameter N_CODE, default 2, meaning code bits per trellis symbol; legal range 2..4. Derived values: CW = 2^N_CODE, MAXS = 2^SYM_W-1, BM_W = SYM_W+$clog2(N_CODE).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  rx_sym/erase valid this cycle.
REQ-007 in_ready  output  1  block accepts the input this cycle.
REQ-008 rx_sym  input  N_CODE*SYM_W  soft value s_i of code bit i at [i*SYM_W +: SYM_W]; unsigned, 0 = confident '0', MAXS = confident '1'.
REQ-009 erase  input  N_CODE  bit i set = code bit i punctured/erased.
REQ-010 out_valid  output  1  bm/out_best valid.
REQ-011 out_ready  input  1  downstream accepts the output this cycle.
REQ-012 bm  output  CW*BM_W  normalised metric of codeword c at [c*BM_W +: BM_W].
REQ-013 out_best  output  N_CODE  codeword index with the smallest metric.
REQ-014 sym_cnt  output  16  count of completed output handshakes.

Function
REQ-015 Accept = in_valid&&in_ready; output handshake = out_valid&&out_ready.
REQ-016 Per-bit distance for codeword c, bit i: 0 if erase[i]; else s_i if c[i]=0; else MAXS-s_i if c[i]=1.
REQ-017 Raw metric raw_c SHALL be the sum over i of the per-bit distances, computed at BM_W bits without overflow (max N_CODE*MAXS).
REQ-018 Stage 1 SHALL register all CW raw metrics and s1_valid on accept.
REQ-019 Stage 2 SHALL register bm_c = raw_c - min(raw), out_best = the lowest index achieving the minimum (ties to the lower index), and s2_valid.
REQ-020 Latency SHALL be exactly 2 cycles from accept to out_valid when out_ready stays high; throughput is 1 symbol per cycle.
REQ-021 Stage 2 SHALL advance when !s2_valid || out_ready; stage 1 SHALL advance when !s1_valid || stage 2 advances; in_ready = !s1_valid || stage-1 advance, combinational from out_ready with no dependency on in_valid.
REQ-022 While out_valid=1 and out_ready=0, bm and out_best SHALL hold stable; no symbol SHALL be dropped, duplicated or reordered.
REQ-023 If all bits are erased, all bm SHALL be 0 and out_best SHALL be 0.
REQ-024 sym_cnt SHALL increment by 1 on each output handshake and wrap from 0xFFFF to 0x0000.
REQ-025 If an accept and an output handshake occur in the same cycle with both stages full, the pipeline SHALL shift with no bubble.

Reset
REQ-026 While rst_n=0, the block SHALL clear s1_valid, s2_valid, all metric registers, out_best and sym_cnt to 0 immediately, independent of clk.
REQ-027 During reset, in_ready=1, out_valid=0 and bm=0.
REQ-028 On a reset mid-stream, the block SHALL discard in-flight symbols; the first accept after rst_n rises SHALL produce the next output.

Verification (defaults SYM_W=3, N_CODE=2 unless stated; metrics listed c0,c1,c2,c3)
REQ-029 Assert reset: after rst_n=0, the bench SHALL observe out_valid=0, bm=0, sym_cnt=0 and in_ready=1.
REQ-030 Send s0=0, s1=7, erase=00: the bench SHALL observe out_valid 2 cycles later with raw 7,14,0,7, bm 7,14,0,7 and out_best=2.
REQ-031 Send s0=2, erase=10 (bit1 erased): the bench SHALL observe raw 2,5,2,5, bm 0,3,0,3 and out_best=0 (tie resolved to the lower index).
REQ-032 Stream 5 symbols with out_ready=0 for cycles 2-4: the bench SHALL observe in_ready fall once 2 symbols are held, outputs held stable, all 5 outputs in order and sym_cnt=5.
REQ-033 Assert rst_n=0 asynchronously with both stages full: the bench SHALL observe out_valid drop within the same cycle, and after release see no stale output appear.
REQ-034 With SYM_W=1, send rx_sym=2'b11: the bench SHALL observe bm 2,1,1,0 and out_best=3; with erase=11, all bm=0 and out_best=0.
